// File: rtl/video_mode_encoder_if.sv
// Handshake between the video mode encoder and the HDMI reconfiguration stage.
// The encoder publishes the mode byte and status strobes; the stage returns reconf_done.
interface video_mode_encoder_if;
  logic [7:0] mode_byte;
  logic       mode_changed;
  logic       reconf_busy;
  logic       reconf_timeout;
  logic       reconf_done;

  modport master (
    output mode_byte,
    output mode_changed,
    output reconf_busy,
    output reconf_timeout,
    input  reconf_done
  );

  modport slave (
    input  mode_byte,
    input  mode_changed,
    input  reconf_busy,
    input  reconf_timeout,
    output reconf_done
  );
endinterface

// File: rtl/video_mode_encoder.sv
// Builds the 7-bit video mode code from output resolution and a frame-filtered source class,
// and publishes it (bit 7 = republish toggle) through a busy / wait-done / hold-off sequence.
module video_mode_encoder #(
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  output_res,
  input  logic [2:0]                  source_mode,
  input  logic                        vsync_pulse,
  input  logic                        force_publish,
  video_mode_encoder_if.master        reconf
);

  typedef enum logic [1:0] {
    IDLE,
    PUBLISH,
    WAIT_DONE,
    HOLDOFF
  } state_t;

  localparam int CW      = $clog2(STABLE_FRAMES + 1);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int TW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLDOFF_LAST = TW'(HOLDOFF_CYCLES - 1);

  state_t        state, state_d;
  logic [TW-1:0] timer;
  logic          publish, timer_clr, timeout_fire;

  logic [2:0]    candidate, candidate_d, accepted;
  logic [CW-1:0] stab_cnt, stab_cnt_d;
  logic [1:0]    res_q;
  logic [6:0]    src_bits, target;

  logic [7:0]    mode_byte_q;
  logic          toggle, force_pending;
  logic          mode_changed_q, timeout_q;

  // Stability filter: next candidate/count for the current sample.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    candidate_d = candidate;
    stab_cnt_d  = stab_cnt;
    if (source_mode >= 3'd6) begin
      stab_cnt_d = '0;
    end else if (source_mode == candidate) begin
      if (stab_cnt != STABLE_LAST) stab_cnt_d = stab_cnt + 1'b1;
    end else begin
      candidate_d = source_mode;
      stab_cnt_d  = CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      stab_cnt  <= '0;
      accepted  <= '0;
      res_q     <= '0;
    end else begin
      res_q <= output_res;
      if (vsync_pulse) begin
        candidate <= candidate_d;
        stab_cnt  <= stab_cnt_d;
        if (stab_cnt_d == STABLE_LAST) accepted <= candidate_d;
      end
    end
  end

  always_comb begin
    case (accepted)
      3'd0:    src_bits = 7'h00;
      3'd1:    src_bits = 7'h04;
      3'd2:    src_bits = 7'h08;
      3'd3:    src_bits = 7'h10;
      3'd4:    src_bits = 7'h20;
      3'd5:    src_bits = 7'h40;
      default: src_bits = 7'h00;
    endcase
    target = src_bits | {5'b0, res_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d      = state;
    publish      = 1'b0;
    timer_clr    = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (target != mode_byte_q[6:0] || force_pending) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish   = 1'b1;
        timer_clr = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Completion takes priority over a timeout expiring on the same cycle.
        if (reconf.reconf_done) begin
          timer_clr = 1'b1;
          state_d   = HOLDOFF;
        end else if (timer == TIMEOUT_LAST) begin
          timer_clr    = 1'b1;
          timeout_fire = 1'b1;
          state_d      = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (timer == HOLDOFF_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer          <= '0;
      mode_byte_q    <= '0;
      toggle         <= 1'b0;
      force_pending  <= 1'b0;
      mode_changed_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      if (timer_clr)                                  timer <= '0;
      else if (state == WAIT_DONE || state == HOLDOFF) timer <= timer + 1'b1;

      // A request arriving during PUBLISH survives and triggers a further republish.
      force_pending  <= force_publish | (force_pending & ~publish);
      mode_changed_q <= publish;
      timeout_q      <= timeout_fire;

      if (publish) begin
        mode_byte_q <= {toggle ^ force_pending, target};
        toggle      <= toggle ^ force_pending;
      end
    end
  end

  assign reconf.mode_byte      = mode_byte_q;
  assign reconf.mode_changed   = mode_changed_q;
  assign reconf.reconf_timeout = timeout_q;
  assign reconf.reconf_busy    = (state != IDLE);

endmodule

// File: tb/tb_video_mode_encoder.sv
// Directed bench for video_mode_encoder: filter acceptance, publish latency, busy sequencing,
// forced republish, timeout / done priority and asynchronous reset.
module tb_video_mode_encoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] output_res;
  logic [2:0] source_mode;
  logic       vsync_pulse;
  logic       force_publish;

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_changes = 0;
  int   base      = 0;
  logic saw_42    = 1'b0;

  video_mode_encoder_if reconf_if();

  video_mode_encoder #(
    .STABLE_FRAMES  (3),
    .TIMEOUT_CYCLES (16),
    .HOLDOFF_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .output_res    (output_res),
    .source_mode   (source_mode),
    .vsync_pulse   (vsync_pulse),
    .force_publish (force_publish),
    .reconf        (reconf_if.master)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reconf_if.mode_changed) n_changes++;
    if (reconf_if.mode_byte[6:0] == 7'h42) saw_42 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_vsync(input logic [2:0] m);
    source_mode = m;
    vsync_pulse = 1'b1;
    tick(1);
    vsync_pulse = 1'b0;
    tick(1);
  endtask

  task automatic pulse_force();
    force_publish = 1'b1;
    tick(1);
    force_publish = 1'b0;
  endtask

  // Called in WAIT_DONE: acknowledge, then verify the 4-cycle hold-off window.
  task automatic ack_and_settle(input string tag);
    reconf_if.reconf_done = 1'b1;
    tick(1);
    reconf_if.reconf_done = 1'b0;
    check({tag, "_strobe_one_cycle"}, 32'(reconf_if.mode_changed), 32'd0);
    check({tag, "_busy_holdoff"}, 32'(reconf_if.reconf_busy), 32'd1);
    tick(3);
    check({tag, "_busy_holdoff_end"}, 32'(reconf_if.reconf_busy), 32'd1);
    tick(1);
    check({tag, "_idle"}, 32'(reconf_if.reconf_busy), 32'd0);
  endtask

  initial begin
    output_res            = 2'd0;
    source_mode           = 3'd0;
    vsync_pulse           = 1'b0;
    force_publish         = 1'b0;
    reconf_if.reconf_done = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("rst_mode_byte", 32'(reconf_if.mode_byte), 32'h00);
    check("rst_changed", 32'(reconf_if.mode_changed), 32'd0);
    check("rst_busy", 32'(reconf_if.reconf_busy), 32'd0);
    check("rst_timeout", 32'(reconf_if.reconf_timeout), 32'd0);
    tick(3);
    check("idle_no_publish", 32'(reconf_if.mode_byte), 32'h00);

    // output_res change: new byte 3 clocks after the drive cycle
    output_res = 2'd1;
    tick(2);
    check("res_early", 32'(reconf_if.mode_byte), 32'h00);
    check("res_busy_publish", 32'(reconf_if.reconf_busy), 32'd1);
    tick(1);
    check("res_publish", 32'(reconf_if.mode_byte), 32'h01);
    check("res_changed", 32'(reconf_if.mode_changed), 32'd1);
    ack_and_settle("res");

    // stable 240p source over three frames -> 0x11
    pulse_vsync(3'd3);
    pulse_vsync(3'd3);
    check("src_two_frames", 32'(reconf_if.mode_byte), 32'h01);
    pulse_vsync(3'd3);
    check("src_early", 32'(reconf_if.mode_byte), 32'h01);
    tick(1);
    check("src_publish", 32'(reconf_if.mode_byte), 32'h11);
    check("src_changed", 32'(reconf_if.mode_changed), 32'd1);
    ack_and_settle("src");

    // unstable sequence 4,4,5,4,4 never reaches three in a row
    pulse_vsync(3'd4);
    pulse_vsync(3'd4);
    pulse_vsync(3'd5);
    pulse_vsync(3'd4);
    pulse_vsync(3'd4);
    tick(3);
    check("unstable_hold", 32'(reconf_if.mode_byte), 32'h11);
    check("unstable_idle", 32'(reconf_if.reconf_busy), 32'd0);
    pulse_vsync(3'd4);
    tick(1);
    check("third_480i", 32'(reconf_if.mode_byte), 32'h21);
    ack_and_settle("i480");

    // invalid sample clears the count: 5,5,7,5,5 holds, next 5 accepts
    pulse_vsync(3'd5);
    pulse_vsync(3'd5);
    pulse_vsync(3'd7);
    pulse_vsync(3'd5);
    pulse_vsync(3'd5);
    tick(3);
    check("invalid_restart", 32'(reconf_if.mode_byte), 32'h21);
    check("invalid_idle", 32'(reconf_if.reconf_busy), 32'd0);
    pulse_vsync(3'd5);
    tick(1);
    check("accept_576i", 32'(reconf_if.mode_byte), 32'h41);
    ack_and_settle("i576");

    // output_res 0 -> 2 -> 3 while busy: only 0x43 is published afterwards
    output_res = 2'd0;
    tick(3);
    check("res0_publish", 32'(reconf_if.mode_byte), 32'h40);
    tick(1);
    base = n_changes;
    output_res = 2'd2;
    tick(2);
    output_res = 2'd3;
    tick(2);
    check("busy_hold_code", 32'(reconf_if.mode_byte), 32'h40);
    reconf_if.reconf_done = 1'b1;
    tick(1);
    reconf_if.reconf_done = 1'b0;
    tick(3);
    check("holdoff_hold_code", 32'(reconf_if.mode_byte), 32'h40);
    tick(1);
    check("back_idle", 32'(reconf_if.reconf_busy), 32'd0);
    tick(2);
    check("latest_published", 32'(reconf_if.mode_byte), 32'h43);
    tick(1);
    check("single_publish", 32'(n_changes - base), 32'd1);
    check("no_0x42", 32'(saw_42), 32'd0);
    ack_and_settle("latest");

    // forced republish flips only bit 7
    output_res = 2'd0;
    tick(3);
    check("res0_again", 32'(reconf_if.mode_byte), 32'h40);
    ack_and_settle("res0");
    pulse_force();
    tick(1);
    check("force1_busy", 32'(reconf_if.reconf_busy), 32'd1);
    tick(1);
    check("force1_byte", 32'(reconf_if.mode_byte), 32'hC0);
    check("force1_changed", 32'(reconf_if.mode_changed), 32'd1);
    ack_and_settle("force1");
    pulse_force();
    tick(2);
    check("force2_byte", 32'(reconf_if.mode_byte), 32'h40);
    ack_and_settle("force2");

    // timeout: no done, strobe 16 clocks into WAIT_DONE, idle 4 clocks later
    pulse_force();
    tick(2);
    check("to_byte", 32'(reconf_if.mode_byte), 32'hC0);
    tick(15);
    check("to_not_yet", 32'(reconf_if.reconf_timeout), 32'd0);
    tick(1);
    check("to_pulse", 32'(reconf_if.reconf_timeout), 32'd1);
    tick(1);
    check("to_one_cycle", 32'(reconf_if.reconf_timeout), 32'd0);
    check("to_holdoff_busy", 32'(reconf_if.reconf_busy), 32'd1);
    tick(2);
    check("to_holdoff_end", 32'(reconf_if.reconf_busy), 32'd1);
    tick(1);
    check("to_idle", 32'(reconf_if.reconf_busy), 32'd0);

    // done on the final WAIT_DONE cycle wins over the timeout
    pulse_force();
    tick(2);
    check("dw_byte", 32'(reconf_if.mode_byte), 32'h40);
    tick(15);
    reconf_if.reconf_done = 1'b1;
    tick(1);
    reconf_if.reconf_done = 1'b0;
    check("done_wins", 32'(reconf_if.reconf_timeout), 32'd0);
    check("dw_holdoff", 32'(reconf_if.reconf_busy), 32'd1);
    tick(1);
    check("dw_no_late_pulse", 32'(reconf_if.reconf_timeout), 32'd0);
    tick(2);
    check("dw_holdoff_end", 32'(reconf_if.reconf_busy), 32'd1);
    tick(1);
    check("dw_idle", 32'(reconf_if.reconf_busy), 32'd0);

    // asynchronous reset in WAIT_DONE
    pulse_force();
    tick(2);
    check("rw_byte", 32'(reconf_if.mode_byte), 32'hC0);
    tick(2);
    base = n_changes;
    #1 reset_n = 1'b0;
    #1;
    check("rw_byte_cleared", 32'(reconf_if.mode_byte), 32'h00);
    check("rw_busy_cleared", 32'(reconf_if.reconf_busy), 32'd0);
    check("rw_no_strobe", 32'(reconf_if.mode_changed), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(4);
    check("rw_post_byte", 32'(reconf_if.mode_byte), 32'h00);
    check("rw_post_idle", 32'(reconf_if.reconf_busy), 32'd0);
    check("rw_no_changes", 32'(n_changes - base), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
